// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two requesters and the shared-ALU arbiter
interface alu_arbiter_if #(
    parameter int N = 32
);
    logic         req_valid_0;
    logic         req_valid_1;
    logic         req_ready_0;
    logic         req_ready_1;
    logic [N-1:0] req_a_0;
    logic [N-1:0] req_a_1;
    logic [N-1:0] req_b_0;
    logic [N-1:0] req_b_1;
    logic [3:0]   req_op_0;
    logic [3:0]   req_op_1;
    logic         rsp_valid_0;
    logic         rsp_valid_1;
    logic         rsp_ready_0;
    logic         rsp_ready_1;
    logic [N-1:0] rsp_z_0;
    logic [N-1:0] rsp_z_1;

    // Requester side: drives operations and accepts results.
    modport master (
        output req_valid_0, req_valid_1,
        output req_a_0, req_a_1, req_b_0, req_b_1, req_op_0, req_op_1,
        input  req_ready_0, req_ready_1,
        input  rsp_valid_0, rsp_valid_1, rsp_z_0, rsp_z_1,
        output rsp_ready_0, rsp_ready_1
    );

    // Arbiter side.
    modport slave (
        input  req_valid_0, req_valid_1,
        input  req_a_0, req_a_1, req_b_0, req_b_1, req_op_0, req_op_1,
        output req_ready_0, req_ready_1,
        output rsp_valid_0, rsp_valid_1, rsp_z_0, rsp_z_1,
        input  rsp_ready_0, rsp_ready_1
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters (optional ALU_ARB_STATS_EN grant counters)

// Unsigned combinational ALU. Opcodes: 0000 and, 0001 or, 0010 add, 0011 sub,
// 0100 mul (low bits), 0101 div, 0110 shl, 0111 shr, 1000 xor, others 0.
module alu #(
    parameter int n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [3:0]   s,
    output logic [n-1:0] y
);
    localparam logic [n-1:0] N_VAL = n'(n);
    localparam int SW = $clog2(n);

    logic [n-1:0] divisor;

    // Divide by a safe value so the datapath never sees a zero divisor.
    assign divisor = (b == '0) ? n'(1) : b;

    // Operation select.
    always_comb begin
        y = '0;
        case (s)
            4'b0000: y = a & b;
            4'b0001: y = a | b;
            4'b0010: y = a + b;
            4'b0011: y = a - b;
            4'b0100: y = a * b;
            4'b0101: y = a / divisor;
            4'b0110: y = (b >= N_VAL) ? '0 : (a << b[SW-1:0]);
            4'b0111: y = (b >= N_VAL) ? '0 : (a >> b[SW-1:0]);
            4'b1000: y = a ^ b;
            default: y = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int N          = 32,
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef ALU_ARB_STATS_EN
    output logic [15:0] grant_cnt_0,
    output logic [15:0] grant_cnt_1,
`endif
    alu_arbiter_if.slave bus
);
    localparam logic [3:0]   OP_MUL   = 4'b0100;
    localparam logic [3:0]   OP_DIV   = 4'b0101;
    localparam logic [3:0]   OP_SHL   = 4'b0110;
    localparam logic [3:0]   OP_SHR   = 4'b0111;
    localparam logic [3:0]   OP_LAST  = 4'b1000;
    localparam logic [3:0]   LAT_M1   = 4'(MULDIV_LAT - 1);
    localparam logic [N-1:0] N_VAL    = N'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         owner_q, owner_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [3:0]   op_q, op_d;
    logic [N-1:0] result_q, result_d;
    logic         rsp_valid_0_q, rsp_valid_0_d;
    logic         rsp_valid_1_q, rsp_valid_1_d;

    logic         grant_0;
    logic         grant_1;
    logic [3:0]   sel_op;
    logic         rsp_hs;
    logic [N-1:0] alu_y;
    logic [N-1:0] capture_val;

    // The ALU only ever sees the operands latched at the request handshake.
    alu #(.n(N)) u_alu (
        .a (a_q),
        .b (b_q),
        .s (op_q),
        .y (alu_y)
    );

    // Round-robin grant, only while idle and out of reset; a tie goes to the port that was not served last.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (rst_n && state_q == IDLE) begin
            if (bus.req_valid_0 && bus.req_valid_1) begin
                grant_0 = last_grant_q;
                grant_1 = ~last_grant_q;
            end else begin
                grant_0 = bus.req_valid_0;
                grant_1 = bus.req_valid_1;
            end
        end
    end

    assign bus.req_ready_0 = grant_0;
    assign bus.req_ready_1 = grant_1;
    assign bus.rsp_valid_0 = rsp_valid_0_q;
    assign bus.rsp_valid_1 = rsp_valid_1_q;
    assign bus.rsp_z_0     = result_q;
    assign bus.rsp_z_1     = result_q;

    assign sel_op = grant_1 ? bus.req_op_1 : bus.req_op_0;
    assign rsp_hs = owner_q ? bus.rsp_ready_1 : bus.rsp_ready_0;

    // Corner-case results forced at capture regardless of what the ALU produced.
    always_comb begin
        capture_val = alu_y;
        if (op_q == OP_DIV && b_q == '0) begin
            capture_val = '1;
        end else if ((op_q == OP_SHL || op_q == OP_SHR) && b_q >= N_VAL) begin
            capture_val = '0;
        end else if (op_q > OP_LAST) begin
            capture_val = '0;
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        result_d      = result_q;
        rsp_valid_0_d = rsp_valid_0_q;
        rsp_valid_1_d = rsp_valid_1_q;
        case (state_q)
            IDLE: begin
                if (grant_0 || grant_1) begin
                    owner_d = grant_1;
                    a_d     = grant_1 ? bus.req_a_1 : bus.req_a_0;
                    b_d     = grant_1 ? bus.req_b_1 : bus.req_b_0;
                    op_d    = sel_op;
                    cnt_d   = (sel_op == OP_MUL || sel_op == OP_DIV) ? LAT_M1 : 4'd0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    result_d      = capture_val;
                    rsp_valid_0_d = ~owner_q;
                    rsp_valid_1_d = owner_q;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    last_grant_d  = owner_q;
                    rsp_valid_0_d = 1'b0;
                    rsp_valid_1_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d       = IDLE;
                rsp_valid_0_d = 1'b0;
                rsp_valid_1_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight op or held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            cnt_q         <= 4'd0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= 4'd0;
            result_q      <= '0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            result_q      <= result_d;
            rsp_valid_0_q <= rsp_valid_0_d;
            rsp_valid_1_q <= rsp_valid_1_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt_0_q, grant_cnt_0_d;
    logic [15:0] grant_cnt_1_q, grant_cnt_1_d;

    // Saturating per-port count of request handshakes.
    always_comb begin
        grant_cnt_0_d = grant_cnt_0_q;
        grant_cnt_1_d = grant_cnt_1_q;
        if (grant_0 && grant_cnt_0_q != 16'hFFFF) begin
            grant_cnt_0_d = grant_cnt_0_q + 16'd1;
        end
        if (grant_1 && grant_cnt_1_q != 16'hFFFF) begin
            grant_cnt_1_d = grant_cnt_1_q + 16'd1;
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_0_q <= 16'd0;
            grant_cnt_1_q <= 16'd0;
        end else begin
            grant_cnt_0_q <= grant_cnt_0_d;
            grant_cnt_1_q <= grant_cnt_1_d;
        end
    end

    assign grant_cnt_0 = grant_cnt_0_q;
    assign grant_cnt_1 = grant_cnt_1_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter
module tb_alu_arbiter;
    localparam int N   = 32;
    localparam int LAT = 4;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;

    typedef struct {
        int          port;
        logic [31:0] z;
        int          cyc;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    int   grant_log[$];
    bit   prev_v[2];
    int   rise_cyc[2];

    alu_arbiter_if #(.N(N)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt_0;
    logic [15:0] grant_cnt_1;
`endif

    alu_arbiter #(.N(N), .MULDIV_LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt_0 (grant_cnt_0),
        .grant_cnt_1 (grant_cnt_1),
`endif
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return a * b;
            4'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd6:    return (b >= 32) ? 32'd0 : a << b;
            4'd7:    return (b >= 32) ? 32'd0 : a >> b;
            4'd8:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // Present one request, wait (bounded) for its grant, record the expectation at the handshake.
    task automatic send(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input bit keep);
        exp_t e;
        bit   rdy;
        int   n;
        if (p == 0) begin
            bus.req_a_0 = a; bus.req_b_0 = b; bus.req_op_0 = op; bus.req_valid_0 = 1'b1;
        end else begin
            bus.req_a_1 = a; bus.req_b_1 = b; bus.req_op_1 = op; bus.req_valid_1 = 1'b1;
        end
        n = 0;
        forever begin
            @(negedge clk);
            rdy = (p == 0) ? bus.req_ready_0 : bus.req_ready_1;
            if (rdy) break;
            n++;
            if (n > 300) begin
                check_eq($sformatf("req_grant_timeout_p%0d", p), 32'd0, 32'd1);
                break;
            end
        end
        if (rdy) begin
            e.port = p;
            e.z    = model(a, b, op);
            e.cyc  = cyc;
            e.lat  = (op == OP_MUL || op == OP_DIV) ? 1 + LAT : 2;
            exp_q.push_back(e);
            grant_log.push_back(p);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (p == 0) bus.req_valid_0 = 1'b0;
            else        bus.req_valid_1 = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: checks latency, owner, value and exclusivity at each response handshake.
    initial begin
        exp_t        e;
        logic        v;
        logic        r;
        logic        other;
        logic [31:0] z;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v[0] = 1'b0;
                prev_v[1] = 1'b0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    v     = (p == 0) ? bus.rsp_valid_0 : bus.rsp_valid_1;
                    r     = (p == 0) ? bus.rsp_ready_0 : bus.rsp_ready_1;
                    other = (p == 0) ? bus.rsp_valid_1 : bus.rsp_valid_0;
                    z     = (p == 0) ? bus.rsp_z_0 : bus.rsp_z_1;
                    if (v && !prev_v[p]) rise_cyc[p] = cyc;
                    prev_v[p] = v;
                    if (v && r) begin
                        if (exp_q.size() == 0) begin
                            check_eq($sformatf("rsp_unexpected_p%0d", p), 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check_eq("rsp_port", p, e.port);
                            check_eq($sformatf("rsp_z_p%0d", p), z, e.z);
                            check_eq("rsp_latency", rise_cyc[p] - e.cyc, e.lat);
                            check_eq("rsp_other_valid", {31'd0, other}, 32'd0);
                        end
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
        bus.req_a_0 = '0; bus.req_b_0 = '0; bus.req_op_0 = '0;
        bus.req_a_1 = '0; bus.req_b_1 = '0; bus.req_op_1 = '0;
        bus.rsp_ready_0 = 1'b1; bus.rsp_ready_1 = 1'b1;

        // Reset state, with a request already pending on port 0.
        repeat (2) @(posedge clk);
        bus.req_valid_0 = 1'b1;
        @(negedge clk);
        check_eq("rst_req_ready_0", {31'd0, bus.req_ready_0}, 32'd0);
        check_eq("rst_req_ready_1", {31'd0, bus.req_ready_1}, 32'd0);
        check_eq("rst_rsp_valid_0", {31'd0, bus.rsp_valid_0}, 32'd0);
        check_eq("rst_rsp_valid_1", {31'd0, bus.rsp_valid_1}, 32'd0);
        check_eq("rst_rsp_z_0", bus.rsp_z_0, 32'd0);
        check_eq("rst_rsp_z_1", bus.rsp_z_1, 32'd0);
        bus.req_valid_0 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Simple add on port 0: ready in the same cycle.
        fork
            send(0, 32'd5, 32'd7, OP_ADD, 1'b0);
        join_none
        @(negedge clk);
        check_eq("t1_req_ready_0", {31'd0, bus.req_ready_0}, 32'd1);
        check_eq("t1_req_ready_1", {31'd0, bus.req_ready_1}, 32'd0);
        wait fork;
        drain();

        // Multi-cycle mul and div-by-zero on port 1.
        send(1, 32'd6, 32'd7, OP_MUL, 1'b0);
        drain();
        send(1, 32'd9, 32'd0, OP_DIV, 1'b0);
        drain();

        // Both ports held valid: grants must alternate starting with port 0.
        grant_log.delete();
        fork
            begin
                send(0, 32'hF0, 32'h3C, OP_AND, 1'b1);
                send(0, 32'hF0, 32'h3C, OP_AND, 1'b0);
            end
            begin
                send(1, 32'hF0, 32'h0F, OP_OR, 1'b1);
                send(1, 32'hF0, 32'h0F, OP_OR, 1'b0);
            end
        join
        drain();
        check_eq("alt_count", grant_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check_eq($sformatf("alt_grant_%0d", i), grant_log[i], i % 2);
        end

        // Held response: port 0 does not accept, port 1 must wait.
        bus.rsp_ready_0 = 1'b0;
        send(0, 32'd100, 32'd23, OP_ADD, 1'b0);
        fork
            send(1, 32'd1, 32'd1, OP_ADD, 1'b0);
        join_none
        for (int n = 0; n < 20 && !bus.rsp_valid_0; n++) @(negedge clk);
        check_eq("hold_rsp_valid_0", {31'd0, bus.rsp_valid_0}, 32'd1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check_eq("hold_rsp_z_0", bus.rsp_z_0, 32'd123);
            check_eq("hold_req_ready_1", {31'd0, bus.req_ready_1}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready_0 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("hold_release_ready_1", {31'd0, bus.req_ready_1}, 32'd1);
        wait fork;
        drain();

        // Mixed operations including shift and opcode boundaries.
        for (int i = 0; i < 14; i++) begin
            int          p;
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            p  = $urandom_range(0, 1);
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 40));
            case (i)
                0: begin op = OP_SHL; b = 32'd32; end
                1: begin op = OP_SHR; b = 32'd31; a = 32'h8000_0000; end
                2: begin op = 4'hF; end
                3: begin op = 4'h9; end
                4: begin op = OP_DIV; b = 32'd0; end
                5: begin op = OP_MUL; a = 32'hFFFF_FFFF; b = 32'd3; end
                6: begin op = OP_SHL; b = 32'd31; end
                default: ;
            endcase
            send(p, a, b, op, 1'b0);
            drain();
        end

        // Async reset during a div: everything drops, port 0 then wins the tie.
        send(0, 32'd3, 32'd4, OP_ADD, 1'b0);
        drain();
        send(1, 32'd100, 32'd7, OP_DIV, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req_ready_0", {31'd0, bus.req_ready_0}, 32'd0);
        check_eq("mid_rst_req_ready_1", {31'd0, bus.req_ready_1}, 32'd0);
        check_eq("mid_rst_rsp_valid_0", {31'd0, bus.rsp_valid_0}, 32'd0);
        check_eq("mid_rst_rsp_valid_1", {31'd0, bus.rsp_valid_1}, 32'd0);
        check_eq("mid_rst_rsp_z", bus.rsp_z_0, 32'd0);
        exp_q.delete();
        grant_log.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fork
            send(0, 32'd11, 32'd22, OP_ADD, 1'b0);
            send(1, 32'd40, 32'd2, OP_ADD, 1'b0);
        join_none
        @(negedge clk);
        check_eq("post_rst_ready_0", {31'd0, bus.req_ready_0}, 32'd1);
        check_eq("post_rst_ready_1", {31'd0, bus.req_ready_1}, 32'd0);
        wait fork;
        drain();
        if (grant_log.size() > 0) check_eq("post_rst_first_grant", grant_log[0], 32'd0);
        else                      check_eq("post_rst_first_grant", 32'd1, 32'd0);

`ifdef ALU_ARB_STATS_EN
        send(0, 32'd1, 32'd2, OP_ADD, 1'b0);
        drain();
        send(1, 32'd1, 32'd2, OP_ADD, 1'b0);
        drain();
        send(0, 32'd1, 32'd2, OP_ADD, 1'b0);
        drain();
        check_eq("grant_cnt_0", {16'd0, grant_cnt_0}, 32'd3);
        check_eq("grant_cnt_1", {16'd0, grant_cnt_1}, 32'd2);
        force dut.grant_cnt_0_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.grant_cnt_0_q;
        send(0, 32'd1, 32'd2, OP_ADD, 1'b0);
        drain();
        check_eq("grant_cnt_0_sat", {16'd0, grant_cnt_0}, 32'h0000_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance between two requesters (e.g. integer execute path and address/branch unit).
- Accepts one operation at a time through valid/ready request ports, using round-robin arbitration.
- Sequences multi-cycle mul/div with a hold counter and returns a registered result on the winner's response port.
- One operation outstanding at a time; the response is held until the owner accepts it.

Parameters:
- N, 32, operand/result width; passed to alu as n.
- MULDIV_LAT, 4, EXEC cycles for opcodes 0100 (mul) and 0101 (div); legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid_0, req_valid_1  input  1  requester i has an operation
- req_ready_0, req_ready_1  output  1  arbiter accepts requester i this cycle
- req_a_0, req_a_1  input  N  operand A
- req_b_0, req_b_1  input  N  operand B
- req_op_0, req_op_1  input  4  ALU select S
- rsp_valid_0, rsp_valid_1  output  1  result for requester i is valid
- rsp_ready_0, rsp_ready_1  input  1  requester i takes the result
- rsp_z_0, rsp_z_1  output  N  result; both driven from one shared result register

Behaviour:
- Reset: state=IDLE, last_grant=1 (port 0 wins first tie), counter=0, result reg=0, owner=0.
  - All req_ready_*=0 and rsp_valid_*=0; rsp_z_* read 0.
  - Reset is asynchronous and may land at any point; an in-flight op or held result is discarded.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready_i is combinational: asserted only for the granted port, only in IDLE.
  - Grant rule: one valid request → that port. Both valid → the port != last_grant. None valid → stay in IDLE.
  - On handshake: latch a, b, op and owner; load counter (MULDIV_LAT-1 for 0100/0101, else 0); go to EXEC.
- EXEC:
  - The ALU sees only the latched operands, never live request inputs.
  - counter!=0 → decrement.
  - counter==0 → capture the result into the result reg and go to RESP.
- RESP:
  - rsp_valid_owner=1; the other port's rsp_valid stays 0.
  - rsp_ready_owner=1 → last_grant=owner, go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake, so peak throughput is one op per 3 cycles.
- Latency, counted from the request-handshake edge t:
  - Simple ops: rsp_valid rises at edge t+2.
  - mul/div: rsp_valid rises at edge t+1+MULDIV_LAT.
- Result rules (applied at capture, overriding the alu output):
  - div with B==0 → all ones.
  - Opcodes 1001..1111 → 0.
  - mul → low N bits of the product.
  - Shifts by B>=N → 0.
  - All arithmetic is unsigned, modulo 2^N.
- Protocol rules:
  - A requester holding valid while not granted must keep a/b/op stable.
  - Request inputs change nothing outside the IDLE handshake.
  - rsp_ready from the non-owner is ignored.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: adds outputs grant_cnt_0 and grant_cnt_1, each 16 bits.
  - Increment on each request handshake of that port; saturate at 16'hFFFF.
  - Reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then port 0 requests op=0010, A=5, B=7 → req_ready_0 in the same cycle; rsp_valid_0 two edges later with rsp_z_0=12; rsp_valid_1 stays 0.
- Both ports hold valid continuously, with port 0 op=0000 (A=F0, B=3C) and port 1 op=0001 (A=F0, B=0F) → grants alternate 0,1,0,1; results 0x30 and 0xFF respectively.
- Port 1 requests op=0100, A=6, B=7, with MULDIV_LAT=4 → rsp_valid_1 at t+5 with value 42; op=0101, A=9, B=0 → 0xFFFFFFFF.
- Result held: rsp_ready_0=0 for 10 cycles while port 1 is valid → rsp_z_0 stable, req_ready_1 stays 0; after rsp_ready_0=1, port 1 is granted on the next cycle.
- rst_n asserted mid-EXEC of a div → all rsp_valid and req_ready drop immediately; after release, port 0 is granted first.
- With ALU_ARB_STATS_EN: 3 grants to port 0 and 2 to port 1 → grant_cnt_0=3, grant_cnt_1=2; forced to 0xFFFF, one more grant leaves it at 0xFFFF.
